// File: rtl/vga_sync_decoder.sv
// VGA receive-side monitor: recovers (x, y, rgb) from HS/VS/BLANK_N/RGB and locks onto the timing.
// Optional VGA_DEC_BLANK_CHECK_EN: while locked, the registered blank_n must match the computed window.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk_25M,
    input  logic       i_rst,
    input  logic       i_hs,
    input  logic       i_vs,
    input  logic       i_blank_n,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b,
    output logic       o_pixel_valid,
    output logic       o_frame_start,
    output logic       o_locked,
    output logic       o_err,
    output logic [9:0] o_h_total,
    output logic [9:0] o_v_total
);

    localparam logic [10:0] H_TOTAL = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [10:0] V_TOTAL = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [9:0]  H_LO    = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  H_HI    = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0]  V_LO    = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_HI    = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
    localparam logic [9:0]  CNT_MAX = 10'h3FF;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t     state, state_nx;
    logic [3:0] good, good_nx;
    logic       line_bad, line_bad_nx;

    logic       hs_q, hs_d, vs_q, vs_d, blank_q;
    logic [7:0] r_q, g_q, b_q;
    logic       hs_fall, vs_fall;

    logic [9:0]  hcnt_r, vcnt_r, hcnt, vcnt;
    logic [10:0] h_period, v_height;
    logic        h_bad, v_bad, h_sat, in_win, blank_bad, frame_ok, viol, pix_vld;

    // Sync idles high so leaving reset never fabricates a falling edge.
    always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
            hs_q    <= 1'b1;
            hs_d    <= 1'b1;
            vs_q    <= 1'b1;
            vs_d    <= 1'b1;
            blank_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            hs_q    <= i_hs;
            hs_d    <= hs_q;
            vs_q    <= i_vs;
            vs_d    <= vs_q;
            blank_q <= i_blank_n;
            r_q     <= i_r;
            g_q     <= i_g;
            b_q     <= i_b;
        end
    end

    assign hs_fall = hs_d & ~hs_q;
    assign vs_fall = vs_d & ~vs_q;

    // hcnt/vcnt are the values belonging to the current registered input cycle.
    always_comb begin
        hcnt = (hcnt_r == CNT_MAX) ? CNT_MAX : hcnt_r + 10'd1;
        if (hs_fall)
            hcnt = '0;
        vcnt = vcnt_r;
        if (vs_fall)
            vcnt = '0;
        else if (hs_fall && vcnt_r != CNT_MAX)
            vcnt = vcnt_r + 10'd1;
    end

    always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
            hcnt_r <= CNT_MAX;
            vcnt_r <= CNT_MAX;
        end else begin
            hcnt_r <= hcnt;
            vcnt_r <= vcnt;
        end
    end

    assign h_period = {1'b0, hcnt_r} + 11'd1;
    assign v_height = {1'b0, vcnt_r} + 11'd1;
    assign h_bad    = hs_fall && (h_period != H_TOTAL);
    assign v_bad    = vs_fall && (v_height != V_TOTAL);
    assign h_sat    = (hcnt == CNT_MAX);
    assign in_win   = (hcnt >= H_LO) && (hcnt <= H_HI) && (vcnt >= V_LO) && (vcnt <= V_HI);
    assign frame_ok = !line_bad && !h_bad && !v_bad;

`ifdef VGA_DEC_BLANK_CHECK_EN
    assign blank_bad = (state == LOCKED) && (blank_q != in_win);
`else
    logic unused_blank;
    assign unused_blank = blank_q;
    assign blank_bad    = 1'b0;
`endif

    always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
            state    <= SEARCH;
            good     <= '0;
            line_bad <= 1'b0;
        end else begin
            state    <= state_nx;
            good     <= good_nx;
            line_bad <= line_bad_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        good_nx     = good;
        line_bad_nx = line_bad;
        viol        = 1'b0;
        // A line that ends on the VS edge still belongs to the frame being judged.
        if (vs_fall)
            line_bad_nx = 1'b0;
        else if (h_bad || h_sat)
            line_bad_nx = 1'b1;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nx = MEASURE;
                    good_nx  = '0;
                end
            end
            MEASURE: begin
                if (vs_fall) begin
                    if (frame_ok) begin
                        good_nx = good + 4'd1;
                        if (good + 4'd1 == LOCK_N)
                            state_nx = LOCKED;
                    end else begin
                        good_nx = '0;
                    end
                end
            end
            LOCKED: begin
                if (h_bad || v_bad || h_sat || blank_bad) begin
                    viol     = 1'b1;
                    state_nx = SEARCH;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    // A violating cycle never emits a pixel, so valid cannot coincide with lock falling.
    assign pix_vld = (state == LOCKED) && !viol && in_win;

    always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
            o_x           <= '0;
            o_y           <= '0;
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
            o_pixel_valid <= 1'b0;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
            o_h_total     <= '0;
            o_v_total     <= '0;
        end else begin
            o_pixel_valid <= pix_vld;
            o_x           <= pix_vld ? hcnt - H_LO : '0;
            o_y           <= pix_vld ? vcnt - V_LO : '0;
            o_r           <= pix_vld ? r_q : '0;
            o_g           <= pix_vld ? g_q : '0;
            o_b           <= pix_vld ? b_q : '0;
            o_frame_start <= pix_vld && (hcnt == H_LO) && (vcnt == V_LO);
            o_locked      <= (state_nx == LOCKED);
            o_err         <= viol;
            if (hs_fall)
                o_h_total <= h_period[9:0];
            if (vs_fall)
                o_v_total <= v_height[9:0];
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced 25x13 raster (16x8 visible).
// Stimulus pushes expected pixels; a monitor branch pops and compares on o_pixel_valid.
module tb_vga_sync_decoder;

    localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
    localparam int VA = 8,  VF = 1, VSY = 2, VB = 2;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int HLO = HSY + HB, HHI = HSY + HB + HA - 1;
    localparam int VLO = VSY + VB, VHI = VSY + VB + VA - 1;

    logic       clk, rst, hs, vs, blank_n;
    logic [7:0] r, g, b;
    logic [9:0] o_x, o_y, o_h_total, o_v_total;
    logic [7:0] o_r, o_g, o_b;
    logic       o_pixel_valid, o_frame_start, o_locked, o_err;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .LOCK_FRAMES(2)
    ) dut (
        .i_clk_25M(clk), .i_rst(rst), .i_hs(hs), .i_vs(vs), .i_blank_n(blank_n),
        .i_r(r), .i_g(g), .i_b(b),
        .o_x(o_x), .o_y(o_y), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_pixel_valid(o_pixel_valid), .o_frame_start(o_frame_start),
        .o_locked(o_locked), .o_err(o_err),
        .o_h_total(o_h_total), .o_v_total(o_v_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int fs_cnt = 0;
    logic [9:0] err_htot = '0;
    logic prev_locked = 1'b0;
    logic [44:0] exp_q[$];
    logic [44:0] exp_pix;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_frame(input int exp_v, input int exp_h, input int short_v, input int long_v,
                               input int rst_v, input int rst_h, input int nob_v, input int nob_h);
        for (int v = 0; v < VT; v++) begin
            int len;
            len = (v == short_v) ? HT - 1 : (v == long_v) ? 1100 : HT;
            for (int h = 0; h < len; h++) begin
                logic act;
                @(negedge clk);
                if (rst) begin
                    check("reset_mid_line_outs",
                          {o_locked, o_pixel_valid, o_err, o_frame_start, o_x, o_y, o_r, o_g, o_b}, 64'd0);
                    check("reset_mid_line_totals", {o_h_total, o_v_total}, 64'd0);
                end
                act     = (v != long_v) && h >= HLO && h <= HHI && v >= VLO && v <= VHI;
                hs      = !((v != long_v) && h < HSY);
                vs      = !(v < VSY);
                blank_n = act && !(v == nob_v && h == nob_h);
                r       = act ? 8'(h - HLO) : 8'hEE;
                g       = act ? 8'(v - VLO) : 8'hEE;
                b       = act ? 8'h5A : 8'hEE;
                rst     = (v == rst_v && h == rst_h);
                if (act && (v < exp_v || (v == exp_v && h < exp_h)))
                    exp_q.push_back({10'(h - HLO), 10'(v - VLO), r, g, b, (h == HLO && v == VLO)});
            end
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (o_pixel_valid) begin
                    exp_pix = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    check("pixel", {o_x, o_y, o_r, o_g, o_b, o_frame_start}, 64'(exp_pix));
                end
                if (o_frame_start) fs_cnt++;
                if (o_err) begin
                    err_cnt++;
                    err_htot = o_h_total;
                    check("lock_falls_with_err", {prev_locked, o_locked}, 64'b10);
                end
                prev_locked = o_locked;
            end
            begin
                hs = 1'b1; vs = 1'b1; blank_n = 1'b0; r = '0; g = '0; b = '0; rst = 1'b1;
                repeat (3) @(negedge clk);
                check("reset_outs", {o_locked, o_pixel_valid, o_err, o_frame_start, o_x, o_y, o_r, o_g, o_b}, 64'd0);
                check("reset_totals", {o_h_total, o_v_total}, 64'd0);
                rst = 1'b0;

                // nominal lock: edge 1 -> MEASURE, edge 3 -> LOCKED
                drive_frame(0, 0, -1, -1, -1, -1, -1, -1);
                check("unlocked_frame0", o_locked, 0);
                drive_frame(0, 0, -1, -1, -1, -1, -1, -1);
                check("unlocked_before_vs3", o_locked, 0);
                drive_frame(VT, 0, -1, -1, -1, -1, -1, -1);
                check("locked_after_vs3", o_locked, 1);
                check("h_total_nominal", o_h_total, HT);
                check("v_total_coincident_edges", o_v_total, VT);
                drive_frame(VT, 0, -1, -1, -1, -1, -1, -1);
                check("frame_starts_2", fs_cnt, 2);
                check("no_err_nominal", err_cnt, 0);

                // short line 5 while locked
                drive_frame(6, 0, 5, -1, -1, -1, -1, -1);
                check("short_line_err", err_cnt, 1);
                check("short_line_h_total", err_htot, HT - 1);
                check("short_line_unlocked", o_locked, 0);
                drive_frame(0, 0, -1, -1, -1, -1, -1, -1);
                drive_frame(0, 0, -1, -1, -1, -1, -1, -1);
                check("relock_not_early", o_locked, 0);
                drive_frame(VT, 0, -1, -1, -1, -1, -1, -1);
                check("relock_after_two_frames", o_locked, 1);
                check("relock_no_new_err", err_cnt, 1);

                // HS held high on line 5 -> hcnt saturates
                drive_frame(5, 0, -1, 5, -1, -1, -1, -1);
                check("saturate_err", err_cnt, 2);
                check("saturate_unlocked", o_locked, 0);
                drive_frame(0, 0, -1, -1, -1, -1, -1, -1);
                drive_frame(0, 0, -1, -1, -1, -1, -1, -1);

                // reset mid-line (line 6, h 10) while locked
                drive_frame(6, 9, -1, -1, 6, 10, -1, -1);
                check("reset_unlocked", o_locked, 0);
                drive_frame(0, 0, -1, -1, -1, -1, -1, -1);
                drive_frame(0, 0, -1, -1, -1, -1, -1, -1);
                check("reset_relock_not_early", o_locked, 0);
                drive_frame(VT, 0, -1, -1, -1, -1, -1, -1);
                check("reset_relocked", o_locked, 1);
                check("reset_no_err", err_cnt, 2);

                // blank_n dropped at x=5, y=3
`ifdef VGA_DEC_BLANK_CHECK_EN
                drive_frame(7, 12, -1, -1, -1, -1, 7, 12);
                check("blank_drop_err", err_cnt, 3);
                check("blank_drop_unlocked", o_locked, 0);
                drive_frame(0, 0, -1, -1, -1, -1, -1, -1);
`else
                drive_frame(VT, 0, -1, -1, -1, -1, 7, 12);
                check("blank_ignored_err", err_cnt, 2);
                check("blank_ignored_locked", o_locked, 1);
                drive_frame(VT, 0, -1, -1, -1, -1, -1, -1);
`endif
                repeat (5) @(negedge clk);
                check("scoreboard_drained", exp_q.size(), 0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join_any
    end

endmodule
